i2c_req_arbiter: RTL and testbench

- Shares the single I2C master between up to NREQ requesters: DAC control, ADC config, housekeeping.
- Each requester presents an address, data, byte count and r/w with a one-cycle load pulse. The block latches it, grants round-robin, drives the master's load, and waits for the master's busy cycle to complete.
- Returns read data and a done/err pulse to the owning requester.
- Sits between the requester FSMs and the I2C master.

---
 rtl/i2c_req_arbiter_if.sv | 41 ++++
 rtl/i2c_req_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Bundle between the requester FSMs, the arbiter and the shared I2C master.
//   req_*        : per-requester request fields (packed, requester i at slice i)
//   req_busy/done/err/overrun, rd_data : per-requester status back to requesters
//   I2C_*        : command to / status from the single I2C master
// slave modport : the arbiter's view.  master modport : the driver side.
interface i2c_req_arbiter_if #(
  parameter int NREQ = 3
);
  logic [7*NREQ-1:0]  req_addr;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_bytes;
  logic [NREQ-1:0]    req_r_w;
  logic [NREQ-1:0]    req_load;
  logic [NREQ-1:0]    req_busy;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic [NREQ-1:0]    req_overrun;
  logic [15:0]        rd_data;
  logic [6:0]         I2C_addr;
  logic [15:0]        I2C_data;
  logic               I2C_bytes;
  logic               I2C_r_w;
  logic               I2C_load;
  logic               I2C_busy;
  logic               I2C_data_ready;
  logic [15:0]        I2C_rd_data;

  modport slave (
    input  req_addr, req_data, req_bytes, req_r_w, req_load,
    input  I2C_busy, I2C_data_ready, I2C_rd_data,
    output req_busy, req_done, req_err, req_overrun, rd_data,
    output I2C_addr, I2C_data, I2C_bytes, I2C_r_w, I2C_load
  );

  modport master (
    output req_addr, req_data, req_bytes, req_r_w, req_load,
    output I2C_busy, I2C_data_ready, I2C_rd_data,
    input  req_busy, req_done, req_err, req_overrun, rd_data,
    input  I2C_addr, I2C_data, I2C_bytes, I2C_r_w, I2C_load
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters.
// Each requester strobes req_load; the request is latched into a per-lane
// holding register, granted in rotation, issued to the master with a
// one-cycle I2C_load, and completed with a one-cycle req_done (+req_err on
// timeout). Read data is returned on rd_data in the req_done cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : i2c_req_arbiter_if.slave (requester and master signals)

// Per-requester capture lane: holding register, pending flag, overrun pulse.
module i2c_req_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [6:0]  addr,
  input  logic [15:0] data,
  input  logic        bytes,
  input  logic        r_w,
  input  logic        busy,
  input  logic        grant,
  output logic        pending,
  output logic        overrun,
  output logic [6:0]  h_addr,
  output logic [15:0] h_data,
  output logic        h_bytes,
  output logic        h_r_w
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      h_addr  <= '0;
      h_data  <= '0;
      h_bytes <= 1'b0;
      h_r_w   <= 1'b0;
    end else begin
      overrun <= load & busy;
      // grant only hits a pending lane, whose busy blocks a new capture
      if (load && !busy) begin
        pending <= 1'b1;
        h_addr  <= addr;
        h_data  <= data;
        h_bytes <= bytes;
        h_r_w   <= r_w;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module i2c_req_arbiter #(
  parameter int NREQ          = 3,
  parameter int START_TIMEOUT = 255,
  parameter int DONE_TIMEOUT  = 65535
) (
  input logic            clk,
  input logic            rst_n,
  i2c_req_arbiter_if.slave bus
);
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (START_TIMEOUT > DONE_TIMEOUT) ? START_TIMEOUT : DONE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ST_LIM = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] DN_LIM = TW'(DONE_TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COMPLETE  = 3'd4;

  logic [2:0]                 state;
  logic [TW-1:0]              timer;
  logic                       err_flag;
  logic [NREQ-1:0]            pending, in_service, busy, grant_vec, overrun;
  logic [NREQ-1:0][6:0]       h_addr;
  logic [NREQ-1:0][15:0]      h_data;
  logic [NREQ-1:0]            h_bytes, h_r_w;
  logic [GW-1:0]              last_grant, win;
  logic                       win_vld;
  logic [15:0]                rd_hold, rd_q;
  logic                       rd_got;
  logic [6:0]                 i2c_addr_q;
  logic [15:0]                i2c_data_q;
  logic                       i2c_bytes_q, i2c_r_w_q, i2c_load_q;

  assign busy = pending | in_service;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    i2c_req_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (bus.req_load[i]),
      .addr    (bus.req_addr[7*i +: 7]),
      .data    (bus.req_data[16*i +: 16]),
      .bytes   (bus.req_bytes[i]),
      .r_w     (bus.req_r_w[i]),
      .busy    (busy[i]),
      .grant   (grant_vec[i]),
      .pending (pending[i]),
      .overrun (overrun[i]),
      .h_addr  (h_addr[i]),
      .h_data  (h_data[i]),
      .h_bytes (h_bytes[i]),
      .h_r_w   (h_r_w[i])
    );
  end

  // k-th candidate in rotation order starting just after the last grant
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int k);
    int s;
    s = int'(last) + 1 + k;
    if (s >= NREQ) s = s - NREQ;
    return GW'(s);
  endfunction

  // Walk candidates from lowest priority to highest so the highest wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pending[rr_idx(last_grant, k)]) begin
        win     = rr_idx(last_grant, k);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (state == S_IDLE && win_vld) grant_vec[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      err_flag    <= 1'b0;
      in_service  <= '0;
      last_grant  <= GW'(NREQ - 1);
      rd_hold     <= '0;
      rd_got      <= 1'b0;
      rd_q        <= '0;
      i2c_addr_q  <= '0;
      i2c_data_q  <= '0;
      i2c_bytes_q <= 1'b0;
      i2c_r_w_q   <= 1'b0;
      i2c_load_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            i2c_addr_q      <= h_addr[win];
            i2c_data_q      <= h_data[win];
            i2c_bytes_q     <= h_bytes[win];
            i2c_r_w_q       <= h_r_w[win];
            i2c_load_q      <= 1'b1;
            in_service[win] <= 1'b1;
            last_grant      <= win;
            err_flag        <= 1'b0;
            rd_got          <= 1'b0;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_load_q <= 1'b0;
          timer      <= '0;
          state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.I2C_busy) begin
            timer <= '0;
            state <= S_WAIT_DONE;
          end else if (timer == ST_LIM) begin
            err_flag <= 1'b1;
            state    <= S_COMPLETE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.I2C_data_ready && i2c_r_w_q) begin
            rd_hold <= bus.I2C_rd_data;
            rd_got  <= 1'b1;
          end
          if (!bus.I2C_busy) begin
            // Read data reaches rd_data only on a clean completion, so a
            // timed-out read leaves the previous value in place.
            if (i2c_r_w_q) begin
              if (bus.I2C_data_ready) rd_q <= bus.I2C_rd_data;
              else if (rd_got)        rd_q <= rd_hold;
            end
            state <= S_COMPLETE;
          end else if (timer == DN_LIM) begin
            err_flag <= 1'b1;
            state    <= S_COMPLETE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COMPLETE: begin
          in_service <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_service is one-hot (the owner) for the whole transaction
  assign bus.req_busy    = busy;
  assign bus.req_done    = in_service & {NREQ{state == S_COMPLETE}};
  assign bus.req_err     = in_service & {NREQ{(state == S_COMPLETE) && err_flag}};
  assign bus.req_overrun = overrun;
  assign bus.rd_data     = rd_q;
  assign bus.I2C_addr    = i2c_addr_q;
  assign bus.I2C_data    = i2c_data_q;
  assign bus.I2C_bytes   = i2c_bytes_q;
  assign bus.I2C_r_w     = i2c_r_w_q;
  assign bus.I2C_load    = i2c_load_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;
  localparam int NREQ = 3;
  localparam int ST   = 16;
  localparam int DT   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus();
  i2c_req_arbiter #(.NREQ(NREQ), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // master model: goes busy for m_len negedges after seeing I2C_load
  bit          m_en = 1'b1;
  bit          m_dr = 1'b1;
  int          m_len = 10;
  int          m_cnt = 0;
  logic [15:0] m_rd = 16'h0;

  // monitor log
  int          ld_cnt = 0, ld_hi = 0, ld_cyc = 0;
  logic [6:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_bytes = 1'b0, ld_rw = 1'b0, prev_ld = 1'b0;
  logic [6:0]  gq[$];
  int          done_cnt[NREQ], done_cyc[NREQ], ov_cnt[NREQ], ov_cyc[NREQ];
  logic        err_at[NREQ];
  logic [15:0] rd_at[NREQ];

  initial begin
    bus.I2C_busy = 1'b0;
    bus.I2C_data_ready = 1'b0;
    bus.I2C_rd_data = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (bus.I2C_load && m_en) m_cnt = m_len;
      else if (m_cnt > 0) m_cnt--;
      bus.I2C_busy = (m_cnt > 0);
      bus.I2C_data_ready = (m_cnt == 1) && m_dr;
      bus.I2C_rd_data = bus.I2C_data_ready ? m_rd : 16'hDEAD;
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      done_cnt[i] = 0; done_cyc[i] = 0; ov_cnt[i] = 0; ov_cyc[i] = 0;
      err_at[i] = 1'b0; rd_at[i] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.I2C_load) begin
        ld_hi++;
        if (!prev_ld) begin
          ld_cnt++; ld_cyc = cyc; ld_addr = bus.I2C_addr; ld_data = bus.I2C_data;
          ld_bytes = bus.I2C_bytes; ld_rw = bus.I2C_r_w; gq.push_back(bus.I2C_addr);
        end
      end
      prev_ld = bus.I2C_load;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_done[i]) begin
          done_cnt[i]++; done_cyc[i] = cyc; err_at[i] = bus.req_err[i]; rd_at[i] = bus.rd_data;
        end
        if (bus.req_overrun[i]) begin ov_cnt[i]++; ov_cyc[i] = cyc; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [15:0] d,
                         input logic b, input logic rw);
    bus.req_addr[7*i +: 7]   = a;
    bus.req_data[16*i +: 16] = d;
    bus.req_bytes[i] = b;
    bus.req_r_w[i]   = rw;
    bus.req_load[i]  = 1'b1;
  endtask

  task automatic wait_done(input int i, input int start, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      if (done_cnt[i] > start) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_load = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.req_addr = '0; bus.req_data = '0; bus.req_bytes = '0; bus.req_r_w = '0; bus.req_load = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (bus.I2C_load !== 1'b0) begin n_bad++; $display("FAIL reset_i2c_load got %0b want 0", bus.I2C_load); end
    n_cmp++; if (bus.req_busy !== 3'b000) begin n_bad++; $display("FAIL reset_req_busy got %b want 000", bus.req_busy); end
    n_cmp++; if (bus.req_done !== 3'b000) begin n_bad++; $display("FAIL reset_req_done got %b want 000", bus.req_done); end
    n_cmp++; if (bus.req_overrun !== 3'b000) begin n_bad++; $display("FAIL reset_overrun got %b want 000", bus.req_overrun); end
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0000", bus.rd_data); end
    n_cmp++; if (bus.I2C_addr !== 7'h0) begin n_bad++; $display("FAIL reset_i2c_addr got %h want 00", bus.I2C_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int t, h0, d0; bit ok;
    m_en = 1'b1; m_len = 10; m_rd = 16'h0;
    d0 = done_cnt[0]; h0 = ld_hi;
    set_req(0, 7'h0D, 16'h1234, 1'b1, 1'b0); t = cyc;
    tick(); bus.req_load = '0;
    n_cmp++; if (bus.req_busy[0] !== 1'b1) begin n_bad++; $display("FAIL wr_busy_t1 got %b want 1", bus.req_busy[0]); end
    wait_done(0, d0, 60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_done_seen got 0 want 1"); end
    n_cmp++; if (ld_cyc !== t + 2) begin n_bad++; $display("FAIL wr_load_cycle got %0d want %0d", ld_cyc, t + 2); end
    n_cmp++; if ({ld_addr, ld_data, ld_bytes, ld_rw} !== {7'h0D, 16'h1234, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL wr_fields got %h/%h/%b/%b want 0d/1234/1/0", ld_addr, ld_data, ld_bytes, ld_rw); end
    n_cmp++; if (ld_hi - h0 !== 1) begin n_bad++; $display("FAIL wr_load_width got %0d want 1", ld_hi - h0); end
    n_cmp++; if (done_cyc[0] !== t + 13) begin n_bad++; $display("FAIL wr_done_cycle got %0d want %0d", done_cyc[0], t + 13); end
    n_cmp++; if (err_at[0] !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", err_at[0]); end
    tick();
    n_cmp++; if (bus.req_done[0] !== 1'b0) begin n_bad++; $display("FAIL wr_done_width got %b want 0", bus.req_done[0]); end
    n_cmp++; if (bus.req_busy[0] !== 1'b0) begin n_bad++; $display("FAIL wr_busy_after got %b want 0", bus.req_busy[0]); end
  endtask

  task automatic test_read();
    int t, d0; bit ok;
    m_len = 6; m_rd = 16'hBEEF; d0 = done_cnt[2];
    set_req(2, 7'h48, 16'h0, 1'b1, 1'b1); t = cyc;
    tick(); bus.req_load = '0;
    wait_done(2, d0, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_done_seen got 0 want 1"); end
    n_cmp++; if (rd_at[2] !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data got %h want beef", rd_at[2]); end
    n_cmp++; if (ld_addr !== 7'h48 || ld_rw !== 1'b1) begin n_bad++; $display("FAIL rd_fields got %h/%b want 48/1", ld_addr, ld_rw); end
    n_cmp++; if (done_cyc[2] !== t + 9) begin n_bad++; $display("FAIL rd_done_cycle got %0d want %0d", done_cyc[2], t + 9); end
    tick();
  endtask

  task automatic test_write_keeps_rd();
    int d0; bit ok;
    m_len = 6; m_rd = 16'h5555; d0 = done_cnt[1];
    set_req(1, 7'h21, 16'hA5A5, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    wait_done(1, d0, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wkeep_done_seen got 0 want 1"); end
    n_cmp++; if (rd_at[1] !== 16'hBEEF) begin n_bad++; $display("FAIL wkeep_rd_data got %h want beef", rd_at[1]); end
    tick();
  endtask

  task automatic test_simultaneous();
    int d1, d2, d0; bit ok;
    do_reset();
    m_len = 5; gq.delete();
    d1 = done_cnt[1]; d2 = done_cnt[2];
    set_req(0, 7'h10, 16'h0010, 1'b0, 1'b0);
    set_req(1, 7'h11, 16'h0011, 1'b0, 1'b0);
    set_req(2, 7'h12, 16'h0012, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    wait_done(1, d1, 80, ok);
    tick();
    set_req(1, 7'h11, 16'h0111, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    wait_done(2, d2, 40, ok);
    wait_done(1, d1 + 1, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sim_done_seen got 0 want 1"); end
    // last grant is now 1, so 2 outranks 0
    d0 = done_cnt[0];
    tick();
    set_req(0, 7'h10, 16'h1010, 1'b0, 1'b0);
    set_req(2, 7'h12, 16'h1212, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    wait_done(0, d0, 80, ok);
    n_cmp++; if (gq.size() !== 6) begin n_bad++; $display("FAIL sim_grant_count got %0d want 6", gq.size()); end
    else begin
      n_cmp++; if ({gq[0], gq[1], gq[2], gq[3]} !== {7'h10, 7'h11, 7'h12, 7'h11})
        begin n_bad++; $display("FAIL sim_order got %h %h %h %h want 10 11 12 11", gq[0], gq[1], gq[2], gq[3]); end
      n_cmp++; if ({gq[4], gq[5]} !== {7'h12, 7'h10})
        begin n_bad++; $display("FAIL sim_rotation got %h %h want 12 10", gq[4], gq[5]); end
    end
    tick();
  endtask

  task automatic test_overrun();
    int t, o, l, d0; bit ok;
    m_len = 8; d0 = done_cnt[1];
    set_req(1, 7'h33, 16'hAAAA, 1'b1, 1'b0); t = cyc;
    tick();
    set_req(1, 7'h34, 16'hBBBB, 1'b0, 1'b1);
    tick(); bus.req_load = '0;
    n_cmp++; if (bus.req_overrun[1] !== 1'b1 || ov_cyc[1] !== t + 2)
      begin n_bad++; $display("FAIL ovr_pulse got %b@%0d want 1@%0d", bus.req_overrun[1], ov_cyc[1], t + 2); end
    wait_done(1, d0, 40, ok);
    n_cmp++; if ({ld_addr, ld_data, ld_rw} !== {7'h33, 16'hAAAA, 1'b0})
      begin n_bad++; $display("FAIL ovr_data got %h/%h/%b want 33/aaaa/0", ld_addr, ld_data, ld_rw); end
    // load in the req_done cycle itself: still busy, so dropped
    o = ov_cnt[1]; l = ld_cnt;
    set_req(1, 7'h35, 16'hCCCC, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    repeat (10) tick();
    n_cmp++; if (ov_cnt[1] !== o + 1) begin n_bad++; $display("FAIL ovr_done_cycle got %0d want %0d", ov_cnt[1], o + 1); end
    n_cmp++; if (ld_cnt !== l) begin n_bad++; $display("FAIL ovr_no_issue got %0d want %0d", ld_cnt, l); end
  endtask

  task automatic test_timeout();
    int t, l0, L, d0, d1; bit ok;
    do_reset();
    m_en = 1'b0; m_len = 5; l0 = ld_cnt; d0 = done_cnt[0]; d1 = done_cnt[1];
    set_req(0, 7'h50, 16'h5050, 1'b0, 1'b1);
    set_req(1, 7'h51, 16'h5151, 1'b0, 1'b0); t = cyc;
    tick(); bus.req_load = '0;
    for (int n = 0; n < 10 && ld_cnt == l0; n++) tick();
    L = ld_cyc;
    tick(); m_en = 1'b1;
    wait_done(0, d0, 60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_done_seen got 0 want 1"); end
    n_cmp++; if (L !== t + 2) begin n_bad++; $display("FAIL to_load_cycle got %0d want %0d", L, t + 2); end
    n_cmp++; if (done_cyc[0] !== L + ST + 2) begin n_bad++; $display("FAIL to_done_cycle got %0d want %0d", done_cyc[0], L + ST + 2); end
    n_cmp++; if (err_at[0] !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", err_at[0]); end
    n_cmp++; if (rd_at[0] !== 16'h0) begin n_bad++; $display("FAIL to_rd_kept got %h want 0000", rd_at[0]); end
    wait_done(1, d1, 40, ok);
    n_cmp++; if (ld_addr !== 7'h51 || ld_cyc !== done_cyc[0] + 2)
      begin n_bad++; $display("FAIL to_next_grant got %h@%0d want 51@%0d", ld_addr, ld_cyc, done_cyc[0] + 2); end
    n_cmp++; if (err_at[1] !== 1'b0) begin n_bad++; $display("FAIL to_next_err got %b want 0", err_at[1]); end
    tick();
  endtask

  task automatic test_done_timeout();
    int d2; bit ok;
    m_len = 200; m_rd = 16'h7777; d2 = done_cnt[2];
    set_req(2, 7'h60, 16'h0, 1'b0, 1'b1);
    tick(); bus.req_load = '0;
    wait_done(2, d2, 120, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dto_done_seen got 0 want 1"); end
    n_cmp++; if (done_cyc[2] !== ld_cyc + DT + 3 || err_at[2] !== 1'b1)
      begin n_bad++; $display("FAIL dto_done got %0d/err%b want %0d/err1", done_cyc[2], err_at[2], ld_cyc + DT + 3); end
    repeat (150) tick();
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_bad++; $display("FAIL dto_rd_kept got %h want 0000", bus.rd_data); end
  endtask

  task automatic test_reset_mid();
    int dsum, l;
    m_len = 30;
    set_req(0, 7'h70, 16'h7070, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    tick();
    n_cmp++; if (bus.I2C_load !== 1'b1) begin n_bad++; $display("FAIL rmid_issue got %b want 1", bus.I2C_load); end
    #1 rst_n = 1'b0; #1;
    n_cmp++; if (bus.I2C_load !== 1'b0) begin n_bad++; $display("FAIL rmid_load_drop got %b want 0", bus.I2C_load); end
    tick(); rst_n = 1'b1; tick();
    set_req(0, 7'h71, 16'h7171, 1'b0, 1'b0);
    tick(); bus.req_load = '0;
    repeat (5) tick();
    n_cmp++; if (bus.req_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", bus.req_busy[0]); end
    #1 rst_n = 1'b0; #1;
    n_cmp++; if ({bus.I2C_load, bus.req_busy, bus.req_done} !== 7'b0)
      begin n_bad++; $display("FAIL rmid_async got %b/%b/%b want 0/000/000", bus.I2C_load, bus.req_busy, bus.req_done); end
    dsum = done_cnt[0] + done_cnt[1] + done_cnt[2]; l = ld_cnt;
    tick(); rst_n = 1'b1;
    repeat (50) tick();
    n_cmp++; if (done_cnt[0] + done_cnt[1] + done_cnt[2] !== dsum || ld_cnt !== l)
      begin n_bad++; $display("FAIL rmid_quiet got done%0d/load%0d want done%0d/load%0d",
        done_cnt[0] + done_cnt[1] + done_cnt[2], ld_cnt, dsum, l); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_write_keeps_rd();
    test_simultaneous();
    test_overrun();
    test_timeout();
    test_done_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
